// File: rtl/game_ctl_pkg.sv
// Shared types and defaults for the game sequencer: mode encoding, controller
// states and the default timing/score constants.
package game_ctl_pkg;

  typedef enum logic [2:0] {
    MODE_MENU  = 3'd0,
    MODE_GAME  = 3'd1,
    MODE_WIN   = 3'd2,
    MODE_LOSE  = 3'd3,
    MODE_DRAW  = 3'd4,
    MODE_ERROR = 3'd5
  } game_mode_t;

  typedef enum logic [2:0] {
    S_MENU  = 3'd0,
    S_INIT  = 3'd1,
    S_GAME  = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4,
    S_DRAW  = 3'd5,
    S_ERROR = 3'd6
  } ctl_state_t;

  localparam int TICK_CYCLES_DEF = 6_500_000;
  localparam int SCORE_W_DEF     = 8;
  localparam int WIN_SCORE_DEF   = 20;

  // S_INIT is invisible to the outside world: it still reads as MENU.
  function automatic game_mode_t state_to_mode(input ctl_state_t s);
    case (s)
      S_GAME:  return MODE_GAME;
      S_WIN:   return MODE_WIN;
      S_LOSE:  return MODE_LOSE;
      S_DRAW:  return MODE_DRAW;
      S_ERROR: return MODE_ERROR;
      default: return MODE_MENU;
    endcase
  endfunction

endpackage

// File: rtl/game_ctl_if.sv
// Handshake bundle between the click/collision decoder (master) and the game
// sequencer (slave).
interface game_ctl_if
  import game_ctl_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
) ();

  logic               start1;
  logic               start2;
  logic               menu;
  logic               won;
  logic               lost;
  logic               draw;
  logic               eaten1;
  logic               eaten2;

  game_mode_t         mode;
  logic               multi;
  logic               map_init;
  logic               step;
  logic               grow1;
  logic               grow2;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;

  modport master (
    output start1, start2, menu, won, lost, draw, eaten1, eaten2,
    input  mode, multi, map_init, step, grow1, grow2, score1, score2
  );

  modport slave (
    input  start1, start2, menu, won, lost, draw, eaten1, eaten2,
    output mode, multi, map_init, step, grow1, grow2, score1, score2
  );

endinterface

// File: rtl/game_ctl_step_timer.sv
// Movement-step timer: wrap counter 0..TICK_CYCLES-1 while enabled, tick in the
// last count. clr wins over en so the first period after a clear is full length.
module step_timer #(
  parameter int TICK_CYCLES = 6_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICK_CYCLES - 1);

  logic [TW-1:0] r_timer;
  logic          w_last;

  assign w_last = (r_timer == LAST);
  assign tick   = en && w_last;

  // Counter register: clear, otherwise advance and wrap at the last count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_timer <= '0;
    end else if (en) begin
      r_timer <= w_last ? '0 : r_timer + TW'(1);
    end
  end

endmodule

// File: rtl/game_ctl.sv
// Game sequencer: menu/start handling, step pulse generation, per-snake scores,
// grow strobes and end-of-game decision.
module game_ctl
  import game_ctl_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int WIN_SCORE   = WIN_SCORE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  game_ctl_if.slave  bus
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);

  ctl_state_t         r_state, w_state_nxt;
  logic               r_multi, w_multi_nxt;
  logic [SCORE_W-1:0] r_score1, r_score2, w_score1_nxt, w_score2_nxt;

  logic               w_tick, w_tmr_clr, w_tmr_en;
  logic               w_step, w_grow1, w_grow2, w_map_init;
  logic               w_reach1, w_reach2;
  logic [1:0]         w_deaths;

  step_timer #(.TICK_CYCLES(TICK_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_tmr_clr),
    .en   (w_tmr_en),
    .tick (w_tick)
  );

  assign w_deaths = 2'(bus.won) + 2'(bus.lost) + 2'(bus.draw);

  // State, mode flag and score registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_MENU;
      r_multi  <= 1'b0;
      r_score1 <= '0;
      r_score2 <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_multi  <= w_multi_nxt;
      r_score1 <= w_score1_nxt;
      r_score2 <= w_score2_nxt;
    end
  end

  // Next state, score updates and strobes; game inputs only matter on a step.
  always_comb begin
    w_state_nxt  = r_state;
    w_multi_nxt  = r_multi;
    w_score1_nxt = r_score1;
    w_score2_nxt = r_score2;
    w_step       = 1'b0;
    w_grow1      = 1'b0;
    w_grow2      = 1'b0;
    w_map_init   = 1'b0;
    w_tmr_clr    = 1'b1;
    w_tmr_en     = 1'b0;
    w_reach1     = 1'b0;
    w_reach2     = 1'b0;

    case (r_state)
      S_MENU: begin
        if (bus.start1 && bus.start2) begin
          w_state_nxt  = S_ERROR;
          w_score1_nxt = '0;
          w_score2_nxt = '0;
        end else if (bus.start1 || bus.start2) begin
          w_state_nxt  = S_INIT;
          w_multi_nxt  = bus.start2;
          w_score1_nxt = '0;
          w_score2_nxt = '0;
        end
      end

      S_INIT: begin
        w_map_init  = 1'b1;
        w_state_nxt = S_GAME;
      end

      S_GAME: begin
        w_tmr_clr = 1'b0;
        w_tmr_en  = 1'b1;
        if (w_tick) begin
          w_step = 1'b1;
          if (w_deaths > 2'd1) begin
            w_state_nxt = S_ERROR;
          end else if (bus.draw) begin
            w_state_nxt = S_DRAW;
          end else if (bus.lost) begin
            w_state_nxt = S_LOSE;
          end else if (bus.won && r_multi) begin
            w_state_nxt = S_WIN;
          end else begin
            // A lone 'won' in single-player has no snake2 behind it; treat as a normal step.
            w_grow1 = bus.eaten1;
            w_grow2 = bus.eaten2 && r_multi;
            if (w_grow1 && (r_score1 != SCORE_MAX)) w_score1_nxt = r_score1 + SCORE_W'(1);
            if (w_grow2 && (r_score2 != SCORE_MAX)) w_score2_nxt = r_score2 + SCORE_W'(1);
            w_reach1 = (w_score1_nxt >= SCORE_WIN);
            w_reach2 = (w_score2_nxt >= SCORE_WIN);
            if (w_reach1 && w_reach2) w_state_nxt = S_DRAW;
            else if (w_reach1)        w_state_nxt = S_WIN;
            else if (w_reach2)        w_state_nxt = S_LOSE;
          end
        end
      end

      S_WIN, S_LOSE, S_DRAW, S_ERROR: begin
        if (bus.menu) w_state_nxt = S_MENU;
      end

      default: w_state_nxt = S_MENU;
    endcase
  end

  assign bus.mode     = state_to_mode(r_state);
  assign bus.multi    = r_multi;
  assign bus.map_init = w_map_init;
  assign bus.step     = w_step;
  assign bus.grow1    = w_grow1;
  assign bus.grow2    = w_grow2;
  assign bus.score1   = r_score1;
  assign bus.score2   = r_score2;

endmodule

// File: tb/tb_game_ctl.sv
// Bench for game_ctl: directed scenarios plus random play, compared every cycle
// against a behavioural model of the game rules.
module tb_game_ctl;
  import game_ctl_pkg::*;

  localparam int TICK = 4;
  localparam int WIN  = 3;
  localparam int SW   = 8;
  localparam int SMAX = 255;

  localparam int P_MENU = 0, P_INIT = 1, P_GAME = 2, P_WIN = 3, P_LOSE = 4, P_DRAW = 5, P_ERROR = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_ctl_if #(.SCORE_W(SW)) bus ();

  game_ctl #(.TICK_CYCLES(TICK), .SCORE_W(SW), .WIN_SCORE(WIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;
  int g1_cnt = 0;

  // model state
  int m_ph = P_MENU;
  bit m_multi = 1'b0;
  int m_s1 = 0, m_s2 = 0;
  int m_cyc = 0;
  bit u_step;
  int u_nd;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit e_step();
    return (m_ph == P_GAME) && ((m_cyc % TICK) == TICK - 1);
  endfunction

  function automatic bit e_death();
    int nd;
    nd = int'(bus.won) + int'(bus.lost) + int'(bus.draw);
    return (nd > 1) || bus.draw || bus.lost || (bus.won && m_multi);
  endfunction

  function automatic int e_mode();
    case (m_ph)
      P_GAME:  return int'(MODE_GAME);
      P_WIN:   return int'(MODE_WIN);
      P_LOSE:  return int'(MODE_LOSE);
      P_DRAW:  return int'(MODE_DRAW);
      P_ERROR: return int'(MODE_ERROR);
      default: return int'(MODE_MENU);
    endcase
  endfunction

  // Reference model: advance on each rising edge from the inputs present there.
  always @(posedge clk) begin
    u_step = e_step();
    u_nd   = int'(bus.won) + int'(bus.lost) + int'(bus.draw);
    if (rst) begin
      m_ph = P_MENU; m_multi = 1'b0; m_s1 = 0; m_s2 = 0; m_cyc = 0;
    end else begin
      case (m_ph)
        P_MENU: begin
          if (bus.start1 && bus.start2) begin
            m_ph = P_ERROR; m_s1 = 0; m_s2 = 0;
          end else if (bus.start1) begin
            m_ph = P_INIT; m_multi = 1'b0; m_s1 = 0; m_s2 = 0;
          end else if (bus.start2) begin
            m_ph = P_INIT; m_multi = 1'b1; m_s1 = 0; m_s2 = 0;
          end
        end
        P_INIT: begin
          m_ph = P_GAME; m_cyc = 0;
        end
        P_GAME: begin
          if (u_step) begin
            if (u_nd > 1)                 m_ph = P_ERROR;
            else if (bus.draw)            m_ph = P_DRAW;
            else if (bus.lost)            m_ph = P_LOSE;
            else if (bus.won && m_multi)  m_ph = P_WIN;
            else begin
              if (bus.eaten1 && m_s1 < SMAX)            m_s1++;
              if (bus.eaten2 && m_multi && m_s2 < SMAX) m_s2++;
              if (m_s1 >= WIN && m_s2 >= WIN) m_ph = P_DRAW;
              else if (m_s1 >= WIN)           m_ph = P_WIN;
              else if (m_s2 >= WIN)           m_ph = P_LOSE;
            end
          end
          m_cyc++;
        end
        default: if (bus.menu) m_ph = P_MENU;
      endcase
    end
  end

  // Compare process: every cycle on the falling edge once reset has been applied.
  always @(negedge clk) begin
    if (started) begin
      check("mode",     32'(bus.mode),     32'(e_mode()));
      check("multi",    32'(bus.multi),    32'(m_multi));
      check("map_init", 32'(bus.map_init), 32'(m_ph == P_INIT));
      check("step",     32'(bus.step),     32'(e_step()));
      check("grow1",    32'(bus.grow1),    32'(e_step() && !e_death() && bus.eaten1));
      check("grow2",    32'(bus.grow2),    32'(e_step() && !e_death() && bus.eaten2 && m_multi));
      check("score1",   32'(bus.score1),   32'(m_s1));
      check("score2",   32'(bus.score2),   32'(m_s2));
      if (bus.grow1 === 1'b1) g1_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.start1 = 0; bus.start2 = 0; bus.menu = 0;
    bus.won = 0; bus.lost = 0; bus.draw = 0; bus.eaten1 = 0; bus.eaten2 = 0;
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait expired, phase %0d", nm, m_ph);
  endtask

  task automatic wait_game();
    for (int i = 0; i < 20 && m_ph != P_GAME; i++) tick();
    if (m_ph != P_GAME) timeout("wait_game");
  endtask

  task automatic wait_step();
    for (int i = 0; i < 20 && !e_step(); i++) tick();
    if (!e_step()) timeout("wait_step");
  endtask

  task automatic wait_not_game();
    for (int i = 0; i < 60 && m_ph == P_GAME; i++) tick();
    if (m_ph == P_GAME) timeout("wait_end");
  endtask

  task automatic to_menu();
    bus.menu = 1; tick(); bus.menu = 0;
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    started = 1'b1;

    // 1: idle in menu
    repeat (10) tick();
    check("idle_mode", 32'(bus.mode), 32'(MODE_MENU));
    check("idle_score1", 32'(bus.score1), 0);

    // 2: single-player start, map_init then a step every TICK cycles
    bus.start1 = 1; tick(); bus.start1 = 0;
    check("init_pulse", 32'(bus.map_init), 1);
    check("init_multi", 32'(bus.multi), 0);
    tick();
    check("game_mode", 32'(bus.mode), 32'(MODE_GAME));
    check("game_c0_step", 32'(bus.step), 0);
    check("game_c0_init", 32'(bus.map_init), 0);
    tick(); tick();
    check("game_c2_step", 32'(bus.step), 0);
    tick();
    check("first_step", 32'(bus.step), 1);
    repeat (9) tick();
    bus.lost = 1; wait_not_game(); bus.lost = 0;
    to_menu();

    // 3: multiplayer, snake1 eats three times and wins
    bus.start2 = 1; tick(); bus.start2 = 0;
    wait_game();
    g1_cnt = 0;
    bus.eaten1 = 1; wait_not_game(); bus.eaten1 = 0;
    tick();
    check("win_mode", 32'(bus.mode), 32'(MODE_WIN));
    check("win_score1", 32'(bus.score1), 3);
    check("win_multi", 32'(bus.multi), 1);
    check("win_grow1_cnt", 32'(g1_cnt), 3);
    to_menu();
    check("back_menu", 32'(bus.mode), 32'(MODE_MENU));

    // 4: off-step won ignored, lost at step
    bus.start2 = 1; tick(); bus.start2 = 0;
    wait_game();
    bus.won = 1; tick(); bus.won = 0;
    check("offstep_won", 32'(bus.mode), 32'(MODE_GAME));
    wait_step();
    bus.lost = 1; bus.eaten1 = 1; tick(); bus.lost = 0;
    check("lose_mode", 32'(bus.mode), 32'(MODE_LOSE));
    bus.start1 = 1; repeat (6) tick(); bus.start1 = 0; bus.eaten1 = 0;
    check("lose_hold", 32'(bus.mode), 32'(MODE_LOSE));
    check("lose_score1", 32'(bus.score1), 0);
    to_menu();
    check("lose_menu", 32'(bus.mode), 32'(MODE_MENU));

    // 5: error paths
    bus.start1 = 1; tick(); bus.start1 = 0;
    wait_game(); wait_step();
    bus.won = 1; bus.lost = 1; tick(); bus.won = 0; bus.lost = 0;
    check("err_death", 32'(bus.mode), 32'(MODE_ERROR));
    to_menu();
    bus.start1 = 1; bus.start2 = 1; tick(); bus.start1 = 0; bus.start2 = 0;
    check("err_start", 32'(bus.mode), 32'(MODE_ERROR));
    to_menu();
    check("err_menu", 32'(bus.mode), 32'(MODE_MENU));

    // 6: reset landing on a step cycle
    bus.start1 = 1; tick(); bus.start1 = 0;
    wait_game(); wait_step();
    bus.eaten1 = 1; tick(); bus.eaten1 = 0;
    check("pre_rst_score1", 32'(bus.score1), 1);
    wait_step();
    rst = 1; tick(); rst = 0;
    check("rst_mode", 32'(bus.mode), 32'(MODE_MENU));
    check("rst_score1", 32'(bus.score1), 0);
    check("rst_step", 32'(bus.step), 0);

    // random play
    for (int i = 0; i < 4000; i++) begin
      bus.start1 = ($urandom_range(0, 7) == 0);
      bus.start2 = ($urandom_range(0, 7) == 0);
      bus.menu   = ($urandom_range(0, 9) == 0);
      bus.won    = ($urandom_range(0, 9) == 0);
      bus.lost   = ($urandom_range(0, 11) == 0);
      bus.draw   = ($urandom_range(0, 13) == 0);
      bus.eaten1 = ($urandom_range(0, 1) == 0);
      bus.eaten2 = ($urandom_range(0, 1) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0;
    clr_in();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
